// File: rtl/helai_video_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : helai_video_frame_writer
//  Purpose  : Collects a video frame from a DE/VS pixel stream into a small
//             FWFT FIFO and emits it as addressed write bursts (req/ack
//             command channel followed by a valid/ready data channel).
//  Options  : HELAI_LINE_CHECK_EN - count each DE run and pulse o_line_err
//             when a run length differs from the latched frame width.
//  Revision : 1.0 - initial release
// ============================================================================
module helai_video_frame_writer #(
   parameter int DATA_WIDTH        = 8,
   parameter int CHANNELS          = 1,
   parameter int INPUT_X_RES_WIDTH = 11,
   parameter int BURST_LEN         = 16,
   parameter int FIFO_ASIZE        = 6
) (
   input  logic                                 i_des_video_pclk,
   input  logic                                 i_reset_n,
   input  logic [INPUT_X_RES_WIDTH-1:0]         i_des_video_width,
   input  logic [INPUT_X_RES_WIDTH-1:0]         i_des_video_height,
   input  logic                                 i_des_video_vs,
   input  logic                                 i_des_video_de,
   input  logic [DATA_WIDTH*CHANNELS-1:0]       i_des_video_pixel,
   output logic                                 o_wr_req,
   input  logic                                 i_wr_ack,
   output logic [2*INPUT_X_RES_WIDTH-1:0]       o_wr_addr,
   output logic [6:0]                           o_wr_len,
   output logic                                 o_wr_valid,
   input  logic                                 i_wr_ready,
   output logic [DATA_WIDTH*CHANNELS-1:0]       o_wr_data,
   output logic                                 o_frame_done,
   output logic                                 o_overflow,
   output logic                                 o_line_err
);

   localparam int                c_word_w    = DATA_WIDTH * CHANNELS;
   localparam int                c_aw        = 2 * INPUT_X_RES_WIDTH;
   localparam int                c_depth     = 1 << FIFO_ASIZE;
   localparam logic [FIFO_ASIZE:0]   c_full      = (FIFO_ASIZE+1)'(c_depth);
   localparam logic [FIFO_ASIZE:0]   c_burst_cnt = (FIFO_ASIZE+1)'(BURST_LEN);
   localparam logic [FIFO_ASIZE:0]   c_cnt_one   = (FIFO_ASIZE+1)'(1);
   localparam logic [FIFO_ASIZE-1:0] c_ptr_one   = FIFO_ASIZE'(1);
   localparam logic [c_aw-1:0]       c_aw_one    = c_aw'(1);
   localparam logic [6:0]            c_burst_len = 7'(BURST_LEN);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_REQ   = 3'd2,
      S_DATA  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                      r_state;
   logic [c_word_w-1:0]         r_mem [c_depth];
   logic [FIFO_ASIZE-1:0]       r_wr_ptr;
   logic [FIFO_ASIZE-1:0]       r_rd_ptr;
   logic [FIFO_ASIZE:0]         r_count;
   logic                        r_vs_d;
   logic [INPUT_X_RES_WIDTH-1:0] r_width;
   logic [INPUT_X_RES_WIDTH-1:0] r_height;
   logic [c_aw-1:0]             r_pix_cnt;
   logic [c_aw-1:0]             r_bptr;
   logic [6:0]                  r_beat;
   logic                        r_wr_req;
   logic                        r_wr_valid;
   logic [c_aw-1:0]             r_wr_addr;
   logic [6:0]                  r_wr_len;
   logic                        r_frame_done;
   logic                        r_overflow;

   logic                        w_vs_rise;
   logic [c_aw-1:0]             w_total;
   logic                        w_active;
   logic                        w_pix_in;
   logic                        w_full;
   logic                        w_fifo_we;
   logic                        w_fifo_re;
   logic                        w_all_in;
   logic [6:0]                  w_burst_len;

   assign w_vs_rise   = i_des_video_vs & ~r_vs_d;
   assign w_total     = {{INPUT_X_RES_WIDTH{1'b0}}, r_width} * {{INPUT_X_RES_WIDTH{1'b0}}, r_height};
   assign w_active    = (r_state == S_ARMED) || (r_state == S_REQ) || (r_state == S_DATA);
   assign w_pix_in    = w_active & i_des_video_de & (r_pix_cnt < w_total) & ~w_vs_rise;
   assign w_full      = (r_count == c_full);
   assign w_fifo_re   = r_wr_valid & i_wr_ready;
   // A full FIFO still takes a pixel when a word leaves on the same edge.
   assign w_fifo_we   = w_pix_in & (~w_full | w_fifo_re);
   assign w_all_in    = (r_pix_cnt == w_total);
   assign w_burst_len = (r_count >= c_burst_cnt) ? c_burst_len : 7'(r_count);

   // Data is gated by valid so the bus reads zero whenever no burst is active.
   assign o_wr_data    = r_wr_valid ? r_mem[r_rd_ptr] : '0;
   assign o_wr_req     = r_wr_req;
   assign o_wr_valid   = r_wr_valid;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_len     = r_wr_len;
   assign o_frame_done = r_frame_done;
   assign o_overflow   = r_overflow;

   // Pixel storage: plain RAM without reset, emptiness is tracked by r_count.
   always_ff @(posedge i_des_video_pclk) begin
      if (w_fifo_we) begin
         r_mem[r_wr_ptr] <= i_des_video_pixel;
      end
   end

   // FIFO pointers and occupancy; a frame start discards everything queued.
   always_ff @(posedge i_des_video_pclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_vs_rise) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_fifo_we) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_fifo_re) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_fifo_we && !w_fifo_re) begin
            r_count <= r_count + c_cnt_one;
         end else if (!w_fifo_we && w_fifo_re) begin
            r_count <= r_count - c_cnt_one;
         end
      end
   end

   // Frame bookkeeping: geometry latch, accepted-pixel count, sticky overflow.
   always_ff @(posedge i_des_video_pclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vs_d     <= 1'b0;
         r_width    <= '0;
         r_height   <= '0;
         r_pix_cnt  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_vs_d <= i_des_video_vs;
         if (w_vs_rise) begin
            r_width    <= i_des_video_width;
            r_height   <= i_des_video_height;
            r_pix_cnt  <= '0;
            r_overflow <= 1'b0;
         end else if (w_pix_in) begin
            // Dropped pixels still advance the count to keep addressing aligned.
            r_pix_cnt <= r_pix_cnt + c_aw_one;
            if (w_full && !w_fifo_re) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   // Burst sequencer: decides when to request, runs the data phase, ends the frame.
   always_ff @(posedge i_des_video_pclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_wr_req     <= 1'b0;
         r_wr_valid   <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_len     <= '0;
         r_beat       <= '0;
         r_bptr       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_vs_rise) begin
            r_wr_req   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_beat     <= '0;
            r_bptr     <= '0;
            r_state    <= ((i_des_video_width == '0) || (i_des_video_height == '0)) ? S_DONE : S_ARMED;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_IDLE;
               S_ARMED: begin
                  if (r_bptr == w_total) begin
                     r_state <= S_DONE;
                  end else if ((r_count >= c_burst_cnt) || ((r_count != '0) && w_all_in)) begin
                     r_wr_len  <= w_burst_len;
                     r_wr_addr <= r_bptr;
                     r_wr_req  <= 1'b1;
                     r_state   <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (i_wr_ack) begin
                     r_wr_req   <= 1'b0;
                     r_wr_valid <= 1'b1;
                     r_beat     <= '0;
                     r_state    <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (w_fifo_re) begin
                     if (r_beat == r_wr_len - 7'd1) begin
                        r_wr_valid <= 1'b0;
                        r_bptr     <= r_bptr + c_aw'(r_wr_len);
                        r_state    <= S_ARMED;
                     end else begin
                        r_beat <= r_beat + 7'd1;
                     end
                  end
               end
               S_DONE: begin
                  r_frame_done <= 1'b1;
                  r_state      <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef HELAI_LINE_CHECK_EN
   localparam logic [INPUT_X_RES_WIDTH:0] c_run_one = (INPUT_X_RES_WIDTH+1)'(1);

   logic                         r_de_d;
   logic [INPUT_X_RES_WIDTH:0]   r_run_cnt;
   logic                         r_line_err;

   // Measure each DE run and flag a length mismatch when the run ends.
   always_ff @(posedge i_des_video_pclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_de_d     <= 1'b0;
         r_run_cnt  <= '0;
         r_line_err <= 1'b0;
      end else begin
         r_de_d     <= i_des_video_de;
         r_line_err <= 1'b0;
         if (i_des_video_de) begin
            if (!r_de_d) begin
               r_run_cnt <= c_run_one;
            end else if (r_run_cnt != '1) begin
               r_run_cnt <= r_run_cnt + c_run_one;
            end
         end else if (r_de_d && (r_run_cnt != {1'b0, r_width})) begin
            r_line_err <= 1'b1;
         end
      end
   end

   assign o_line_err = r_line_err;
`else
   assign o_line_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_helai_video_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_helai_video_frame_writer
//  Purpose  : Scoreboard bench for helai_video_frame_writer. Stimulus pushes
//             expected bursts, words, frame-done and line-error events; a
//             negedge monitor pops and compares whatever the DUT presents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_helai_video_frame_writer;

   localparam int AW = 22;
   localparam int BL = 16;
`ifdef HELAI_LINE_CHECK_EN
   localparam bit LINE_CHK = 1'b1;
`else
   localparam bit LINE_CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [10:0]   width, height;
   logic          vs, de;
   logic [7:0]    pix;
   logic          req, ack;
   logic [AW-1:0] addr;
   logic [6:0]    len;
   logic          valid, rdy;
   logic [7:0]    data;
   logic          done, ovf, lerr;

   always #5 clk = ~clk;

   helai_video_frame_writer dut (
      .i_des_video_pclk   (clk),
      .i_reset_n          (rst_n),
      .i_des_video_width  (width),
      .i_des_video_height (height),
      .i_des_video_vs     (vs),
      .i_des_video_de     (de),
      .i_des_video_pixel  (pix),
      .o_wr_req           (req),
      .i_wr_ack           (ack),
      .o_wr_addr          (addr),
      .o_wr_len           (len),
      .o_wr_valid         (valid),
      .i_wr_ready         (rdy),
      .o_wr_data          (data),
      .o_frame_done       (done),
      .o_overflow         (ovf),
      .o_line_err         (lerr)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [6:0]    len;
   } burst_t;

   int        checks   = 0;
   int        failures = 0;
   burst_t    exp_burst[$];
   logic [7:0] exp_data[$];
   int        exp_done = 0;
   int        exp_line = 0;
   int        m_w = 0, m_total = 0, m_acc = 0, m_keep = 0;
   int        ack_dly = -1;
   bit        hold_ack = 1'b0;
   int        ready_mode = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
      end
   endfunction

   function automatic void fail_evt(input string name, input logic [63:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got 0x%0h, want no such event", name, act);
   endfunction

   // ---------------- monitor ----------------
   bit         req_seen = 1'b0;
   burst_t     cap;
   bit         held = 1'b0;
   logic [7:0] held_d;
   burst_t     e;

   always @(negedge clk) begin
      if (!rst_n) begin
         req_seen = 1'b0;
         held     = 1'b0;
      end else begin
         if (req) begin
            if (!req_seen) begin
               req_seen = 1'b1;
               cap.addr = addr;
               cap.len  = len;
               if (exp_burst.size() == 0) begin
                  fail_evt("unexpected_burst", {addr, len});
               end else begin
                  e = exp_burst.pop_front();
                  check("burst_addr", 64'(addr), 64'(e.addr));
                  check("burst_len", 64'(len), 64'(e.len));
               end
            end else begin
               check("req_hold", 64'({addr, len}), 64'({cap.addr, cap.len}));
            end
         end else begin
            req_seen = 1'b0;
         end
         if (held) begin
            check("data_hold", 64'({valid, data}), 64'({1'b1, held_d}));
         end
         held   = valid && !rdy;
         held_d = data;
         if (valid && rdy) begin
            if (exp_data.size() == 0) fail_evt("unexpected_word", 64'(data));
            else check("data", 64'(data), 64'(exp_data.pop_front()));
         end
         if (done) begin
            check("frame_done_expected", 64'(exp_done > 0), 64'd1);
            if (exp_done > 0) exp_done--;
         end
         if (lerr) begin
            check("line_err_expected", 64'(exp_line > 0), 64'd1);
            if (exp_line > 0) exp_line--;
         end
      end
   end

   // ---------------- write-command responder ----------------
   initial begin
      int d;
      ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && req && !hold_ack) begin
            d = (ack_dly < 0) ? int'($urandom_range(0, 2)) : ack_dly;
            repeat (d) begin @(posedge clk); #1; end
            if (rst_n && req && !hold_ack) begin
               ack = 1'b1;
               @(posedge clk); #1;
               ack = 1'b0;
            end
         end
      end
   end

   // ---------------- data-channel ready ----------------
   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: rdy = ($urandom_range(0, 9) != 0);
         endcase
      end
   end

   // ---------------- stimulus / reference model ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   // kept = pixels that land in the FIFO. Only whole bursts drain unless every
   // pixel of the frame made it in, in which case a tail burst finishes it.
   task automatic start_frame(input int w, input int h, input int kept);
      int n_out;
      m_w     = w;
      m_total = w * h;
      m_acc   = 0;
      n_out   = (kept == m_total) ? m_total : (kept / BL) * BL;
      m_keep  = n_out;
      for (int a = 0; a < n_out; a += BL) begin
         burst_t b;
         b.addr = AW'(a);
         b.len  = 7'(((n_out - a) < BL) ? (n_out - a) : BL);
         exp_burst.push_back(b);
      end
      if (kept == m_total) exp_done++;
      width  = 11'(w);
      height = 11'(h);
      vs     = 1'b1;
      tick();
      vs     = 1'b0;
   endtask

   task automatic drive_run(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         de  = 1'b1;
         pix = 8'($urandom);
         if (m_acc < m_total) begin
            if (m_acc < m_keep) exp_data.push_back(pix);
            m_acc++;
         end
         tick();
      end
      de = 1'b0;
      if (LINE_CHK && n > 0 && n != m_w) exp_line++;
      repeat (gap) tick();
   endtask

   task automatic wait_drain(input int budget, input logic exp_ovf);
      int t = 0;
      while ((exp_burst.size() != 0 || exp_data.size() != 0 || exp_done != 0) && t < budget) begin
         tick();
         t++;
      end
      if (t >= budget) begin
         fail_evt("drain_timeout", 64'(exp_burst.size() + exp_data.size() + exp_done));
         exp_burst.delete();
         exp_data.delete();
         exp_done = 0;
      end
      repeat (4) tick();
      check("line_err_pending", 64'(exp_line), 64'd0);
      check("overflow", 64'(ovf), 64'(exp_ovf));
   endtask

   initial begin
      int t;
      bit seen;
      int w, h;
      rst_n = 1'b0; width = '0; height = '0; vs = 1'b0; de = 1'b0; pix = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({req, valid, done, ovf, lerr, addr, len, data}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Pixels before any frame start are ignored and no request appears.
      drive_run(4, 2);
      repeat (5) tick();
      check("idle_no_req", 64'(req), 64'd0);
      wait_drain(50, 1'b0);

      // 32x2, ready high, ack one cycle after request.
      ready_mode = 0; ack_dly = 1;
      start_frame(32, 2, 64);
      drive_run(32, 4);
      drive_run(32, 4);
      wait_drain(2000, 1'b0);

      // 20x1: full burst followed by a 4-word tail.
      start_frame(20, 1, 20);
      drive_run(20, 3);
      wait_drain(2000, 1'b0);

      // Ready toggling during the burst.
      ready_mode = 1; ack_dly = -1;
      start_frame(16, 1, 16);
      drive_run(16, 2);
      wait_drain(2000, 1'b0);

      // Zero-sized frames complete at once with no request.
      ready_mode = 2;
      start_frame(0, 5, 0);
      drive_run(3, 2);
      wait_drain(200, 1'b0);
      start_frame(5, 0, 0);
      wait_drain(200, 1'b0);

      // Ack withheld: 80 pixels into a 64-deep FIFO.
      ready_mode = 0; hold_ack = 1'b1;
      start_frame(80, 1, 64);
      drive_run(80, 1);
      check("overflow_set", 64'(ovf), 64'd1);
      hold_ack = 1'b0;
      wait_drain(2000, 1'b1);
      start_frame(8, 1, 8);
      check("overflow_cleared", 64'(ovf), 64'd0);
      drive_run(8, 2);
      wait_drain(2000, 1'b0);

      // Short line: 31-pixel run against a width of 32.
      start_frame(32, 1, 31);
      drive_run(31, 3);
      wait_drain(2000, 1'b0);

      // Randomised frames.
      ready_mode = 2; ack_dly = -1;
      for (int f = 0; f < 10; f++) begin
         w = $urandom_range(1, 40);
         h = $urandom_range(1, 3);
         start_frame(w, h, w * h);
         for (int l = 0; l < h; l++) drive_run(w, $urandom_range(20, 40));
         if ($urandom_range(0, 1) == 1) drive_run(3, 2);
         wait_drain(3000, 1'b0);
      end

      // Reset in the middle of a data phase.
      ready_mode = 0;
      start_frame(48, 1, 48);
      drive_run(48, 1);
      t = 0;
      while (!valid && t < 200) begin tick(); t++; end
      if (t >= 200) fail_evt("wait_data_timeout", 64'(t));
      rst_n = 1'b0;
      #1;
      check("reset_mid_burst", 64'({req, valid, done, ovf, lerr, addr, len, data}), 64'd0);
      exp_burst.delete(); exp_data.delete(); exp_done = 0; exp_line = 0;
      m_w = 0; m_total = 0; m_acc = 0; m_keep = 0;
      tick(); tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (req) seen = 1'b1;
      end
      check("no_req_after_reset", 64'(seen), 64'd0);

      // Recovery after the next frame start.
      ready_mode = 2;
      start_frame(24, 2, 48);
      drive_run(24, 25);
      drive_run(24, 25);
      wait_drain(3000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
